// File: rtl/msg_request_queue_if.sv
// Handshake bundle between session_manager, msg_request_queue and create_message.
// The master side drives orders, flush and done; the slave side is the queue.
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 8
`endif

interface msg_request_queue_if #(
  parameter int VALUE_WIDTH = `VALUE_DATA_WIDTH,
  parameter int SIZE        = `VALUE_SIZE,
  parameter int DEPTH       = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   initiate_msg_i;
  logic [3:0]             create_message_i;
  logic [VALUE_WIDTH-1:0] targetCompId_i;
  logic [SIZE-1:0]        s_v_targetCompId_i;
  logic                   flush_i;
  logic                   done_i;

  logic                   initiate_msg_o;
  logic [3:0]             create_message_o;
  logic [VALUE_WIDTH-1:0] targetCompId_o;
  logic [SIZE-1:0]        s_v_targetCompId_o;
  logic                   busy_o;
  logic [CW-1:0]          count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   overflow_o;
  logic [7:0]             drop_cnt_o;
  logic                   timeout_err_o;

  modport master (
    output initiate_msg_i, create_message_i, targetCompId_i, s_v_targetCompId_i,
           flush_i, done_i,
    input  initiate_msg_o, create_message_o, targetCompId_o, s_v_targetCompId_o,
           busy_o, count_o, full_o, empty_o, overflow_o, drop_cnt_o, timeout_err_o
  );

  modport slave (
    input  initiate_msg_i, create_message_i, targetCompId_i, s_v_targetCompId_i,
           flush_i, done_i,
    output initiate_msg_o, create_message_o, targetCompId_o, s_v_targetCompId_o,
           busy_o, count_o, full_o, empty_o, overflow_o, drop_cnt_o, timeout_err_o
  );
endinterface

// File: rtl/msg_request_queue.sv
// Order queue between session_manager and create_message: buffers orders in a
// FIFO and issues them one at a time, waiting for done_i (or a watchdog expiry)
// before releasing the next one.
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 8
`endif

module msg_request_queue #(
  parameter int VALUE_WIDTH    = `VALUE_DATA_WIDTH,
  parameter int SIZE           = `VALUE_SIZE,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  msg_request_queue_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 + VALUE_WIDTH + SIZE;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   init_q, init_d;
  logic [3:0]             type_q, type_d;
  logic [VALUE_WIDTH-1:0] id_q, id_d;
  logic [SIZE-1:0]        size_q, size_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             drop_q, drop_d;

  logic [EW-1:0]          mem_q [DEPTH];
  logic [EW-1:0]          entry;
  logic [EW-1:0]          head;
  logic                   push_req;
  logic                   has_room;
  logic                   pop;
  logic                   push;
  logic                   drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decode this edge's push/pop/drop decisions from the handshake and queue state.
  always_comb begin
    entry    = {bus.create_message_i, bus.targetCompId_i, bus.s_v_targetCompId_i};
    head     = mem_q[rd_ptr_q];
    push_req = bus.initiate_msg_i && (bus.create_message_i != 4'b0000);
    has_room = (count_q != CW'(DEPTH));
    // A pop is only possible while idle; flush suppresses it along with any push.
    pop      = (state_q == IDLE) && (count_q != '0) && !bus.flush_i;
    push     = push_req && !bus.flush_i && (has_room || pop);
    drop     = push_req && !bus.flush_i && !has_room && !pop;
  end

  // Issue FSM: launch the head order, then hold until done_i or watchdog expiry.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    init_d  = 1'b0;
    to_d    = 1'b0;
    type_d  = type_q;
    id_d    = id_q;
    size_d  = size_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          type_d  = head[EW-1 -: 4];
          id_d    = head[SIZE +: VALUE_WIDTH];
          size_d  = head[SIZE-1:0];
          init_d  = 1'b1;
          busy_d  = 1'b1;
          wd_d    = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.done_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the order; it is not requeued.
          to_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      init_d  = 1'b0;
      to_d    = 1'b0;
      wd_d    = '0;
    end
  end

  // FIFO bookkeeping and drop accounting.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | drop;
    drop_d  = drop ? sat_inc8(drop_q) : drop_q;
  end

  // Control and issued-order registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      wd_q     <= '0;
      init_q   <= 1'b0;
      type_q   <= '0;
      id_q     <= '0;
      size_q   <= '0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      wd_q     <= wd_d;
      init_q   <= init_d;
      type_q   <= type_d;
      id_q     <= id_d;
      size_q   <= size_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Order storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end

  assign bus.initiate_msg_o     = init_q;
  assign bus.create_message_o   = type_q;
  assign bus.targetCompId_o     = id_q;
  assign bus.s_v_targetCompId_o = size_q;
  assign bus.busy_o             = busy_q;
  assign bus.count_o            = count_q;
  assign bus.full_o             = full_q;
  assign bus.empty_o            = empty_q;
  assign bus.overflow_o         = ovf_q;
  assign bus.drop_cnt_o         = drop_q;
  assign bus.timeout_err_o      = to_q;

endmodule

// File: tb/tb_msg_request_queue.sv
// Bench for msg_request_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_msg_request_queue;

  localparam int VW    = 32;
  localparam int SZ    = 8;
  localparam int DEPTH = 8;
  localparam int T     = 20;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [3:0] LOGON     = 4'h1;
  localparam logic [3:0] LOGOUT    = 4'h2;
  localparam logic [3:0] HEARTBEAT = 4'h3;
  localparam logic [3:0] RESENDREQ = 4'h4;

  typedef struct packed {
    logic [3:0]    t;
    logic [VW-1:0] id;
    logic [SZ-1:0] sz;
  } ord_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  msg_request_queue_if #(.VALUE_WIDTH(VW), .SIZE(SZ), .DEPTH(DEPTH)) bus ();

  msg_request_queue #(
    .VALUE_WIDTH(VW), .SIZE(SZ), .DEPTH(DEPTH), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  ord_t    m_q[$];
  ord_t    m_out;
  bit      m_busy, m_pulse, m_to, m_ovf;
  int      m_drops;
  longint  m_issue_cyc;
  longint  cyc;

  // Bench bookkeeping
  int      n_pass, n_fail, n_total;
  logic [3:0] issue_log[$];
  longint     issue_cyc_log[$];
  longint     done_edge_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic i, input logic [3:0] c, input logic [VW-1:0] id,
                       input logic [SZ-1:0] sz, input logic f, input logic d);
    bus.initiate_msg_i     = i;
    bus.create_message_i   = c;
    bus.targetCompId_i     = id;
    bus.s_v_targetCompId_i = sz;
    bus.flush_i            = f;
    bus.done_i             = d;
  endtask

  // Apply this edge's inputs to the model, following the queue's rules directly.
  task automatic model_update();
    bit   pop, req;
    ord_t in_ord;
    cyc++;
    m_pulse = 0;
    m_to    = 0;
    if (!rst) begin
      m_q.delete();
      m_out   = '0;
      m_busy  = 0;
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      in_ord = {bus.create_message_i, bus.targetCompId_i, bus.s_v_targetCompId_i};
      pop = !m_busy && (m_q.size() != 0) && !bus.flush_i;
      req = bus.initiate_msg_i && (bus.create_message_i != 4'h0);
      if (bus.flush_i) begin
        m_q.delete();
        m_busy = 0;
      end else begin
        if (m_busy) begin
          if (bus.done_i) m_busy = 0;
          else if (cyc - m_issue_cyc == T) begin
            m_busy = 0;
            m_to   = 1;
          end
        end
        if (pop) begin
          m_out       = m_q.pop_front();
          m_busy      = 1;
          m_issue_cyc = cyc;
          m_pulse     = 1;
        end
        if (req) begin
          if (m_q.size() < DEPTH) m_q.push_back(in_ord);
          else begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("initiate_msg_o", 64'(bus.initiate_msg_o), 64'(m_pulse));
    check("create_message_o", 64'(bus.create_message_o), 64'(m_out.t));
    check("targetCompId_o", 64'(bus.targetCompId_o), 64'(m_out.id));
    check("s_v_targetCompId_o", 64'(bus.s_v_targetCompId_o), 64'(m_out.sz));
    check("busy_o", 64'(bus.busy_o), 64'(m_busy));
    check("count_o", 64'(bus.count_o), 64'(m_q.size()));
    check("full_o", 64'(bus.full_o), 64'(m_q.size() == DEPTH));
    check("empty_o", 64'(bus.empty_o), 64'(m_q.size() == 0));
    check("overflow_o", 64'(bus.overflow_o), 64'(m_ovf));
    check("drop_cnt_o", 64'(bus.drop_cnt_o), 64'(m_drops));
    check("timeout_err_o", 64'(bus.timeout_err_o), 64'(m_to));
    if (bus.initiate_msg_o === 1'b1) begin
      issue_log.push_back(bus.create_message_o);
      issue_cyc_log.push_back(cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    longint t_issue;
    int     pulses;
    n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
    m_out = '0; m_busy = 0; m_ovf = 0; m_drops = 0; m_issue_cyc = 0;
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);

    // 1. Reset held with an order presented
    rst = 1'b0;
    drive(1'b1, LOGON, 32'h11, 8'd2, 1'b0, 1'b0);
    repeat (3) step();
    check("rst_empty", 64'(bus.empty_o), 64'd1);
    check("rst_count", 64'(bus.count_o), 64'd0);
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;

    // 2. Single order
    drive(1'b1, LOGON, 32'h41, 8'd1, 1'b0, 1'b0);
    step();
    check("t2_no_early_pulse", 64'(bus.initiate_msg_o), 64'd0);
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    step();
    check("t2_pulse", 64'(bus.initiate_msg_o), 64'd1);
    check("t2_type", 64'(bus.create_message_o), 64'(LOGON));
    check("t2_id", 64'(bus.targetCompId_o), 64'h41);
    check("t2_size", 64'(bus.s_v_targetCompId_o), 64'd1);
    step();
    check("t2_pulse_one_cycle", 64'(bus.initiate_msg_o), 64'd0);
    check("t2_busy", 64'(bus.busy_o), 64'd1);
    check("t2_id_held", 64'(bus.targetCompId_o), 64'h41);
    step();
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    check("t2_busy_cleared", 64'(bus.busy_o), 64'd0);
    step();

    // 3. Back-pressure: later orders queue while the first awaits done_i
    issue_log.delete(); issue_cyc_log.delete(); done_edge_log.delete();
    drive(1'b1, LOGON, 32'h2, 8'd1, 1'b0, 1'b0);      step();
    drive(1'b1, HEARTBEAT, 32'h3, 8'd2, 1'b0, 1'b0);  step();
    drive(1'b1, RESENDREQ, 32'h4, 8'd3, 1'b0, 1'b0);  step();
    drive(1'b1, LOGOUT, 32'h5, 8'd4, 1'b0, 1'b0);     step();
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    repeat (2) step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
      step();
      done_edge_log.push_back(cyc);
      drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
      repeat (3) step();
    end
    check("t3_issue_count", 64'(issue_log.size()), 64'd4);
    if (issue_log.size() == 4) begin
      check("t3_order0", 64'(issue_log[0]), 64'(LOGON));
      check("t3_order1", 64'(issue_log[1]), 64'(HEARTBEAT));
      check("t3_order2", 64'(issue_log[2]), 64'(RESENDREQ));
      check("t3_order3", 64'(issue_log[3]), 64'(LOGOUT));
      for (int k = 0; k < 3; k++)
        check("t3_bubble_after_done", 64'(issue_cyc_log[k+1] - done_edge_log[k]), 64'd1);
    end

    // 4. Overflow while the FSM waits for done_i
    drive(1'b1, HEARTBEAT, 32'hA0, 8'd5, 1'b0, 1'b0); step();
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);            step();
    for (int k = 0; k < DEPTH + 3; k++) begin
      drive(1'b1, 4'(1 + (k % 4)), $urandom, 8'($urandom), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    check("t4_count_full", 64'(bus.count_o), 64'(DEPTH));
    check("t4_full", 64'(bus.full_o), 64'd1);
    check("t4_overflow", 64'(bus.overflow_o), 64'd1);
    check("t4_drops", 64'(bus.drop_cnt_o), 64'd3);
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b1); step();
    drive(1'b1, LOGOUT, 32'hBEEF, 8'd7, 1'b0, 1'b0); step();
    t_issue = cyc;
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    check("t4_same_edge_pop_push", 64'(bus.count_o), 64'(DEPTH));
    check("t4_same_edge_issue", 64'(bus.initiate_msg_o), 64'd1);
    check("t4_drops_held", 64'(bus.drop_cnt_o), 64'd3);

    // 5. Watchdog expiry
    for (int k = 0; k < 3 * T; k++) begin
      step();
      if (bus.timeout_err_o === 1'b1) break;
    end
    check("t5_timeout_distance", 64'(cyc - t_issue), 64'(T));
    check("t5_busy_dropped", 64'(bus.busy_o), 64'd0);
    step();
    check("t5_next_issue", 64'(bus.initiate_msg_o), 64'd1);
    check("t5_timeout_one_cycle", 64'(bus.timeout_err_o), 64'd0);

    // 6. Flush with queued orders, then a code-0 order
    check("t6_queued_before_flush", 64'(bus.count_o >= 4), 64'd1);
    drive(1'b1, LOGON, 32'h77, 8'd1, 1'b1, 1'b0); step();
    check("t6_count", 64'(bus.count_o), 64'd0);
    check("t6_busy", 64'(bus.busy_o), 64'd0);
    check("t6_drops_kept", 64'(bus.drop_cnt_o), 64'd3);
    check("t6_overflow_kept", 64'(bus.overflow_o), 64'd1);
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.initiate_msg_o === 1'b1) pulses++;
    end
    check("t6_no_pulse_after_flush", 64'(pulses), 64'd0);
    drive(1'b1, 4'h0, 32'h99, 8'd3, 1'b0, 1'b0); step();
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    check("t6_code0_count", 64'(bus.count_o), 64'd0);
    check("t6_code0_drops", 64'(bus.drop_cnt_o), 64'd3);
    step();

    // Drop counter saturation: push every cycle, never acknowledge
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 4'($urandom_range(1, 4)), $urandom, 8'($urandom), 1'b0, 1'b0);
      step();
    end
    check("sat_drops", 64'(bus.drop_cnt_o), 64'd255);

    // Random traffic including flush, stray done_i and mid-run resets
    for (int k = 0; k < 500; k++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 4)), $urandom, 8'($urandom),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) == 0));
      rst = ($urandom_range(0, 63) != 0);
      step();
    end
    rst = 1'b1;
    drive(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
